// File: rtl/hps_system_sw_poller_pkg.sv
// Shared types and width helpers for the HPS switch poller and its debounce stage.
package hps_system_sw_poller_pkg;

  localparam int AVM_ADDR_W = 2;
  localparam int AVM_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT   = 2'd2,
    ST_UPDATE = 2'd3
  } poll_state_e;

  // Bits needed for a counter spanning 0 .. n_vals-1 (never less than one bit).
  function automatic int cnt_w(input int n_vals);
    return (n_vals < 2) ? 1 : $clog2(n_vals);
  endfunction

endpackage

// File: rtl/hps_system_sw_debounce.sv
// Debounces polled switch samples: requires STABLE_COUNT equal samples before
// accepting a value, then emits per-bit rise/fall pulses against the old state.
module hps_system_sw_debounce
  import hps_system_sw_poller_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int STABLE_COUNT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              upd_vld_p1,
  input  logic [DATA_W-1:0] sample_p1,
  output logic [DATA_W-1:0] sw_state,
  output logic              sw_valid,
  output logic [DATA_W-1:0] sw_rise,
  output logic [DATA_W-1:0] sw_fall
);

  localparam int              SC_W   = cnt_w(STABLE_COUNT + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STABLE_COUNT);

  function automatic logic [SC_W-1:0] sat_inc(input logic [SC_W-1:0] v);
    return (v >= SC_MAX) ? SC_MAX : v + 1'b1;
  endfunction

  logic [DATA_W-1:0] prev_p2;
  logic [SC_W-1:0]   stable_cnt_p2;
  logic [SC_W-1:0]   stable_nxt;
  logic              same;
  logic              load;

  // Compare against the previous sample and decide whether to accept it.
  always_comb begin
    same       = (sample_p1 == prev_p2);
    stable_nxt = same ? sat_inc(stable_cnt_p2) : SC_W'(1);
    load       = upd_vld_p1 && (stable_nxt == SC_MAX) &&
                 ((sample_p1 != sw_state) || !sw_valid);
  end

  // Debounced state and single-cycle edge pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_p2       <= '0;
      stable_cnt_p2 <= '0;
      sw_state      <= '0;
      sw_valid      <= 1'b0;
      sw_rise       <= '0;
      sw_fall       <= '0;
    end else begin
      sw_rise <= '0;
      sw_fall <= '0;
      if (upd_vld_p1) begin
        stable_cnt_p2 <= stable_nxt;
        if (!same) prev_p2 <= sample_p1;
      end
      if (load) begin
        sw_state <= sample_p1;
        if (sw_valid) begin
          sw_rise <= sample_p1 & ~sw_state;
          sw_fall <= ~sample_p1 & sw_state;
        end else begin
          sw_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hps_system_sw_poller.sv
// Periodically reads the switch PIO data register over Avalon-MM and feeds the
// sampled switch field into the debounce stage.
module hps_system_sw_poller
  import hps_system_sw_poller_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int POLL_CYCLES  = 50000,
  parameter int STABLE_COUNT = 3,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic [AVM_ADDR_W-1:0] avm_address,
  output logic                  avm_read,
  input  logic                  avm_waitrequest,
  input  logic [AVM_DATA_W-1:0] avm_readdata,
  output logic [DATA_W-1:0]     sw_state,
  output logic                  sw_valid,
  output logic [DATA_W-1:0]     sw_rise,
  output logic [DATA_W-1:0]     sw_fall
);

  localparam int              PC_W      = cnt_w(POLL_CYCLES);
  localparam int              LC_W      = cnt_w(READ_LATENCY);
  localparam logic [PC_W-1:0] POLL_LAST = PC_W'(POLL_CYCLES - 1);
  localparam logic [LC_W-1:0] LAT_LAST  = LC_W'(READ_LATENCY - 1);

  poll_state_e       state, state_nxt;
  logic [PC_W-1:0]   poll_cnt, poll_cnt_nxt;
  logic [LC_W-1:0]   lat_cnt, lat_cnt_nxt;
  logic              capture_p0;
  logic [DATA_W-1:0] sample_p1;
  logic              upd_vld_p1;
  logic              unused_rd;

  assign avm_address = '0;
  assign unused_rd   = ^avm_readdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      poll_cnt <= '0;
      lat_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      poll_cnt <= poll_cnt_nxt;
      lat_cnt  <= lat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    poll_cnt_nxt = poll_cnt;
    lat_cnt_nxt  = lat_cnt;
    capture_p0   = 1'b0;
    avm_read     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!enable) begin
          poll_cnt_nxt = '0;
        end else if (poll_cnt == POLL_LAST) begin
          poll_cnt_nxt = '0;
          state_nxt    = ST_REQ;
        end else begin
          poll_cnt_nxt = poll_cnt + 1'b1;
        end
      end
      ST_REQ: begin
        avm_read = 1'b1;
        if (!avm_waitrequest) begin
          lat_cnt_nxt = '0;
          state_nxt   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_cnt == LAT_LAST) begin
          capture_p0 = 1'b1;
          state_nxt  = ST_UPDATE;
        end else begin
          lat_cnt_nxt = lat_cnt + 1'b1;
        end
      end
      ST_UPDATE: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Stage p1: captured switch field, consumed by the debounce while in UPDATE.
  always_ff @(posedge clk) begin
    if (capture_p0) sample_p1 <= avm_readdata[DATA_W-1:0];
  end

  assign upd_vld_p1 = (state == ST_UPDATE);

  hps_system_sw_debounce #(
    .DATA_W       (DATA_W),
    .STABLE_COUNT (STABLE_COUNT)
  ) u_debounce (
    .clk        (clk),
    .reset      (reset),
    .upd_vld_p1 (upd_vld_p1),
    .sample_p1  (sample_p1),
    .sw_state   (sw_state),
    .sw_valid   (sw_valid),
    .sw_rise    (sw_rise),
    .sw_fall    (sw_fall)
  );

endmodule
